// File: rtl/pdec_llr_loader_if.sv
// -----------------------------------------------------------------------------
// pdec_llr_loader_if
// Groups the LLR input stream and the LLR SRAM bank write port of the loader.
//   in_valid / in_ready / in_llr / in_last : channel LLR beat stream, 8 LLRs
//                                            per beat, LLR j at [WID_IN*j +: WID_IN]
//   ulr2sram_llr_wen   : one-hot bank write enable (8 banks)
//   ulr2sram_llr_waddr : per-bank word address, 8 fields of WID_LLR_ADDR bits
//   ulr2sram_llr_wbyte : byte enables, 10 per bank
//   ulr2sram_llr_wdata : write data, bank b at [WID_INN*8*b +: WID_INN*8]
// Modports:
//   master : beat source and SRAM-port observer (upstream side)
//   slave  : the loader itself
// -----------------------------------------------------------------------------
interface pdec_llr_loader_if #(
    parameter int WID_IN       = 8,
    parameter int WID_INN      = 10,
    parameter int WID_LLR_ADDR = 6
);
    logic                      in_valid;
    logic                      in_ready;
    logic [WID_IN*8-1:0]       in_llr;
    logic                      in_last;

    logic [7:0]                ulr2sram_llr_wen;
    logic [WID_LLR_ADDR*8-1:0] ulr2sram_llr_waddr;
    logic [79:0]               ulr2sram_llr_wbyte;
    logic [WID_INN*64-1:0]     ulr2sram_llr_wdata;

    modport master (
        output in_valid, in_llr, in_last,
        input  in_ready,
        input  ulr2sram_llr_wen, ulr2sram_llr_waddr, ulr2sram_llr_wbyte, ulr2sram_llr_wdata
    );

    modport slave (
        input  in_valid, in_llr, in_last,
        output in_ready,
        output ulr2sram_llr_wen, ulr2sram_llr_waddr, ulr2sram_llr_wbyte, ulr2sram_llr_wdata
    );
endinterface

// File: rtl/pdec_llr_loader.sv
// -----------------------------------------------------------------------------
// pdec_llr_loader
// Loads one polar-decoder frame of channel LLRs into the 8 interleaved LLR
// SRAM banks. Received beats (8 LLRs each) are width-converted from WID_IN to
// WID_INN and written one word per beat; beats past the received length are
// zero-filled up to the code length, then load_done pulses.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   cfg_start    : frame start pulse, honoured only when idle
//   cfg_n_log    : log2(N), clamped to 6..WID_LLR_ADDR+6
//   cfg_e_beats  : received beats (E/8), clipped to the frame length
//   bus          : LLR input stream + LLR SRAM write port (slave modport)
//   load_busy    : high from start acceptance until load_done
//   load_done    : one-cycle pulse after the final SRAM write
//   err_len      : sticky in_last misplacement flag, cleared on next start
// -----------------------------------------------------------------------------
module pdec_llr_loader #(
    parameter int WID_IN       = 8,
    parameter int WID_INN      = 10,
    parameter int WID_LLR_ADDR = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_start,
    input  logic [3:0]              cfg_n_log,
    input  logic [WID_LLR_ADDR+3:0] cfg_e_beats,
    pdec_llr_loader_if.slave        bus,
    output logic                    load_busy,
    output logic                    load_done,
    output logic                    err_len
);
    localparam int CW = WID_LLR_ADDR + 3;                     // beat counter width
    localparam int WX = ((WID_IN > WID_INN) ? WID_IN : WID_INN) + 1;
    localparam logic [3:0] NLOG_MIN = 4'd6;
    localparam logic [3:0] NLOG_MAX = 4'(WID_LLR_ADDR + 6);
    localparam logic [CW:0] ONE     = 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FILL, S_DONE} state_t;

    // Sign-extend when widening; otherwise saturate symmetrically so the most
    // negative input never produces an asymmetric stored value.
    function automatic logic signed [WID_INN-1:0] conv_llr(input logic signed [WID_IN-1:0] x);
        logic signed [WX-1:0] xe;
        logic signed [WX-1:0] lim;
        xe  = WX'(x);
        lim = WX'((1 << (WID_INN - 1)) - 1);
        if (WID_IN <= WID_INN)
            return WID_INN'(xe);
        if (xe > lim)
            return WID_INN'(lim);
        if (xe < -lim)
            return WID_INN'(-lim);
        return WID_INN'(xe);
    endfunction

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   t_last;      // T-1, latched at start
    logic [CW-1:0]   e_last;      // Eeff-1, latched at start
    logic            e_full;      // Eeff == T: no fill phase

    logic [3:0]      n_cl;
    logic [CW:0]     t_calc;
    logic [CW:0]     e_calc;

    logic            start_acc;
    logic            accept;
    logic            wr_en;
    logic            wr_zero;

    logic [WID_INN*8-1:0]      word_cv;
    logic [7:0]                wen_nxt;
    logic [79:0]               wbyte_nxt;
    logic [WID_INN*64-1:0]     wdata_nxt;

    logic [7:0]                wen_p1;
    logic [79:0]               wbyte_p1;
    logic [WID_INN*64-1:0]     wdata_p1;
    logic [WID_LLR_ADDR*8-1:0] waddr_p1;

    // Frame geometry from the configuration inputs (used only at start)
    always_comb begin
        n_cl = cfg_n_log;
        if (cfg_n_log < NLOG_MIN)
            n_cl = NLOG_MIN;
        else if (cfg_n_log > NLOG_MAX)
            n_cl = NLOG_MAX;
        t_calc = ONE << (n_cl - 4'd3);
        e_calc = (cfg_e_beats < t_calc) ? cfg_e_beats : t_calc;
    end

    always_comb begin
        state_nxt = state;
        start_acc = 1'b0;
        accept    = 1'b0;
        wr_en     = 1'b0;
        wr_zero   = 1'b0;
        case (state)
            S_IDLE: begin
                if (cfg_start) begin
                    start_acc = 1'b1;
                    state_nxt = (e_calc == '0) ? S_FILL : S_LOAD;
                end
            end
            S_LOAD: begin
                if (bus.in_valid) begin
                    accept = 1'b1;
                    wr_en  = 1'b1;
                    if (cnt == e_last)
                        state_nxt = e_full ? S_DONE : S_FILL;
                end
            end
            S_FILL: begin
                wr_en   = 1'b1;
                wr_zero = 1'b1;
                if (cnt == t_last)
                    state_nxt = S_DONE;
            end
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign bus.in_ready = (state == S_LOAD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            t_last    <= '0;
            e_last    <= '0;
            e_full    <= 1'b0;
            load_busy <= 1'b0;
            load_done <= 1'b0;
            err_len   <= 1'b0;
        end else begin
            state     <= state_nxt;
            load_done <= (state == S_DONE);
            if (start_acc) begin
                cnt       <= '0;
                t_last    <= CW'(t_calc - ONE);
                e_last    <= CW'(e_calc - ONE);
                e_full    <= (e_calc == t_calc);
                load_busy <= 1'b1;
                err_len   <= 1'b0;
            end else if (wr_en) begin
                cnt <= cnt + 1'b1;
            end
            if (state == S_DONE)
                load_busy <= 1'b0;
            // in_last must coincide exactly with the final received beat
            if (accept && (bus.in_last != (cnt == e_last)))
                err_len <= 1'b1;
        end
    end

    // Stage p0: convert the beat and steer it into the bank slot of cnt
    always_comb begin
        word_cv = '0;
        for (int j = 0; j < 8; j++) begin
            if (!wr_zero)
                word_cv[WID_INN*j +: WID_INN] = conv_llr($signed(bus.in_llr[WID_IN*j +: WID_IN]));
        end
    end

    always_comb begin
        wen_nxt   = '0;
        wbyte_nxt = '0;
        wdata_nxt = '0;
        for (int b = 0; b < 8; b++) begin
            if (cnt[2:0] == 3'(b)) begin
                wen_nxt[b]                           = 1'b1;
                wbyte_nxt[10*b +: 10]                = 10'h3FF;
                wdata_nxt[WID_INN*8*b +: WID_INN*8]  = word_cv;
            end
        end
    end

    // Stage p1: registered SRAM write port; data/address hold between writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wen_p1   <= '0;
            wbyte_p1 <= '0;
            wdata_p1 <= '0;
            waddr_p1 <= '0;
        end else begin
            wen_p1   <= wr_en ? wen_nxt : 8'h00;
            wbyte_p1 <= wr_en ? wbyte_nxt : 80'h0;
            if (wr_en) begin
                wdata_p1 <= wdata_nxt;
                waddr_p1 <= {8{cnt[CW-1:3]}};
            end
        end
    end

    assign bus.ulr2sram_llr_wen   = wen_p1;
    assign bus.ulr2sram_llr_wbyte = wbyte_p1;
    assign bus.ulr2sram_llr_wdata = wdata_p1;
    assign bus.ulr2sram_llr_waddr = waddr_p1;

endmodule

// File: tb/tb_pdec_llr_loader.sv
// -----------------------------------------------------------------------------
// tb_pdec_llr_loader
// Self-checking bench for pdec_llr_loader. A frame-level model expands each
// configured frame into its ordered list of expected SRAM writes; a monitor
// compares every write cycle and every idle cycle against it. A second
// instance with 12-bit inputs exercises the saturating conversion.
// -----------------------------------------------------------------------------
module tb_pdec_llr_loader;
    localparam int WIN  = 8;
    localparam int WINN = 10;
    localparam int WA   = 6;
    localparam int CKW  = 640;
    localparam int LGN  = 4096;

    logic            clk;
    logic            rst_n;
    logic            cfg_start;
    logic [3:0]      cfg_n_log;
    logic [WA+3:0]   cfg_e_beats;
    logic            load_busy, load_done, err_len;

    logic            cfg_start12;
    logic [3:0]      cfg_n_log12;
    logic [WA+3:0]   cfg_e_beats12;
    logic            busy12, done12, err12;

    pdec_llr_loader_if #(.WID_IN(WIN), .WID_INN(WINN), .WID_LLR_ADDR(WA)) bus ();
    pdec_llr_loader_if #(.WID_IN(12), .WID_INN(WINN), .WID_LLR_ADDR(WA)) bus12 ();

    pdec_llr_loader #(.WID_IN(WIN), .WID_INN(WINN), .WID_LLR_ADDR(WA)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_n_log(cfg_n_log),
        .cfg_e_beats(cfg_e_beats), .bus(bus), .load_busy(load_busy),
        .load_done(load_done), .err_len(err_len)
    );

    pdec_llr_loader #(.WID_IN(12), .WID_INN(WINN), .WID_LLR_ADDR(WA)) dut12 (
        .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start12), .cfg_n_log(cfg_n_log12),
        .cfg_e_beats(cfg_e_beats12), .bus(bus12), .load_busy(busy12),
        .load_done(done12), .err_len(err12)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [7:0]        wen;
        logic [8*WA-1:0]   addr;
        logic [79:0]       wbyte;
        logic [WINN*64-1:0] wdata;
        bit                zero;
    } wr_t;

    wr_t          expq[$];
    logic [63:0]  beat_q[$];
    int           n_cmp = 0;
    int           n_bad = 0;
    int           cyc = 0;
    int           done_cnt = 0;
    int           done_cyc = 0;
    bit           ready_seen = 0;
    logic [WINN*64-1:0] hold_d = '0;
    logic [8*WA-1:0]    hold_a = '0;

    int                 lg_n = 0;
    logic [7:0]         lg_wen [LGN];
    logic [8*WA-1:0]    lg_addr[LGN];
    logic [WINN*64-1:0] lg_data[LGN];
    int                 lg_cyc [LGN];

    task automatic chk(input string nm, input logic [CKW-1:0] act, input logic [CKW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Stored value of one LLR: plain integer sign handling plus clipping.
    function automatic logic [WINN-1:0] conv_m(input logic [WIN-1:0] x);
        int v, lim;
        v   = int'($signed(x));
        lim = (1 << (WINN - 1)) - 1;
        if (WIN > WINN) begin
            if (v > lim)  v = lim;
            if (v < -lim) v = -lim;
        end
        return WINN'(v);
    endfunction

    // Beat i of a T-beat frame lands in bank i%8 at address i/8; beats past
    // the received count carry zeros.
    task automatic push_frame(input int T, input int ee);
        for (int i = 0; i < T; i++) begin
            wr_t e;
            int b;
            logic [WA-1:0] a;
            b       = i % 8;
            a       = WA'(i / 8);
            e.wen   = 8'(1 << b);
            e.addr  = {8{a}};
            e.wbyte = 80'(10'h3FF) << (10 * b);
            e.wdata = '0;
            e.zero  = (i >= ee);
            if (i < ee)
                for (int j = 0; j < 8; j++)
                    e.wdata[80*b + 10*j +: 10] = conv_m(beat_q[i][8*j +: 8]);
            expq.push_back(e);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Monitor: every cycle is either an expected write or an idle/hold cycle.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                hold_d = '0;
                hold_a = '0;
            end else begin
                if (bus.ulr2sram_llr_wen != 8'h00) begin
                    if (lg_n < LGN) begin
                        lg_wen[lg_n]  = bus.ulr2sram_llr_wen;
                        lg_addr[lg_n] = bus.ulr2sram_llr_waddr;
                        lg_data[lg_n] = bus.ulr2sram_llr_wdata;
                        lg_cyc[lg_n]  = cyc;
                        lg_n++;
                    end
                    if (expq.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_write: got wen %0h expected no write", bus.ulr2sram_llr_wen);
                    end else begin
                        e = expq.pop_front();
                        chk("wen", CKW'(bus.ulr2sram_llr_wen), CKW'(e.wen));
                        chk("waddr", CKW'(bus.ulr2sram_llr_waddr), CKW'(e.addr));
                        chk("wbyte", CKW'(bus.ulr2sram_llr_wbyte), CKW'(e.wbyte));
                        chk("wdata", CKW'(bus.ulr2sram_llr_wdata), CKW'(e.wdata));
                        if (e.zero)
                            chk("ready_during_fill", CKW'(bus.in_ready), CKW'(0));
                        hold_d = e.wdata;
                        hold_a = e.addr;
                    end
                end else begin
                    chk("idle_wbyte", CKW'(bus.ulr2sram_llr_wbyte), CKW'(0));
                    chk("hold_wdata", CKW'(bus.ulr2sram_llr_wdata), CKW'(hold_d));
                    chk("hold_waddr", CKW'(bus.ulr2sram_llr_waddr), CKW'(hold_a));
                end
                if (bus.in_ready)
                    ready_seen = 1'b1;
                if (load_done) begin
                    done_cnt++;
                    done_cyc = cyc;
                    chk("done_writes_pending", CKW'(expq.size()), CKW'(0));
                end
            end
        end
    end

    task automatic run_frame(input int nlog, input int eb, input int lastpos, input bit gaps,
                             input bit poke, input bit pat80, output int base);
        int nc, T, ee, lp, idx, budget, d0, k;
        bit exp_err, acc, v;
        nc = (nlog < 6) ? 6 : ((nlog > WA + 6) ? WA + 6 : nlog);
        T  = 1 << (nc - 3);
        ee = (eb < T) ? eb : T;
        lp = (lastpos < 0) ? ee - 1 : lastpos;
        exp_err = (ee > 0) && (lp != ee - 1);
        beat_q.delete();
        for (int i = 0; i < ee; i++)
            beat_q.push_back({$urandom, $urandom});
        if (pat80 && ee > 0)
            beat_q[0] = {8{8'h80}};
        push_frame(T, ee);
        base = lg_n;
        d0 = done_cnt;
        ready_seen = 1'b0;

        @(negedge clk);
        cfg_start   = 1'b1;
        cfg_n_log   = 4'(nlog);
        cfg_e_beats = 10'(eb);
        @(negedge clk);
        cfg_start = 1'b0;
        chk("busy_after_start", CKW'(load_busy), CKW'(1));
        chk("err_cleared_at_start", CKW'(err_len), CKW'(0));

        idx = 0;
        budget = 0;
        while (idx < ee && budget < 40 * ee + 100) begin
            v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.in_valid = v;
            bus.in_llr   = beat_q[idx];
            bus.in_last  = (idx == lp);
            if (poke && idx == 2) begin
                cfg_start   = 1'b1;
                cfg_n_log   = 4'd9;
                cfg_e_beats = 10'd1;
            end else begin
                cfg_start = 1'b0;
            end
            acc = v && bus.in_ready;
            @(negedge clk);
            budget++;
            if (acc) idx++;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        cfg_start    = 1'b0;
        if (idx < ee) begin
            n_cmp++;
            n_bad++;
            $display("FAIL beat_budget: got %0d beats accepted expected %0d", idx, ee);
        end

        k = 0;
        while (done_cnt == d0 && k < 4 * T + 100) begin
            @(negedge clk);
            k++;
        end
        chk("load_done_count", CKW'(done_cnt - d0), CKW'(1));
        chk("err_len", CKW'(err_len), CKW'(exp_err));
        chk("busy_after_done", CKW'(load_busy), CKW'(0));
        chk("write_count", CKW'(lg_n - base), CKW'(T));
        chk("writes_left", CKW'(expq.size()), CKW'(0));
        if (lg_n > 0)
            chk("done_latency", CKW'(done_cyc), CKW'(lg_cyc[lg_n-1] + 1));
        if (ee == 0)
            chk("ready_never_high", CKW'(ready_seen), CKW'(0));
    endtask

    initial begin
        int base, cnt12, k;
        rst_n = 1'b0;
        cfg_start = 1'b0; cfg_n_log = 4'd6; cfg_e_beats = '0;
        cfg_start12 = 1'b0; cfg_n_log12 = 4'd6; cfg_e_beats12 = '0;
        bus.in_valid = 1'b0; bus.in_llr = '0; bus.in_last = 1'b0;
        bus12.in_valid = 1'b0; bus12.in_llr = '0; bus12.in_last = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_wen", CKW'(bus.ulr2sram_llr_wen), CKW'(0));
        chk("rst_wbyte", CKW'(bus.ulr2sram_llr_wbyte), CKW'(0));
        chk("rst_waddr", CKW'(bus.ulr2sram_llr_waddr), CKW'(0));
        chk("rst_wdata", CKW'(bus.ulr2sram_llr_wdata), CKW'(0));
        chk("rst_ready", CKW'(bus.in_ready), CKW'(0));
        chk("rst_busy", CKW'(load_busy), CKW'(0));
        chk("rst_done", CKW'(load_done), CKW'(0));
        chk("rst_err", CKW'(err_len), CKW'(0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Full frame, back-to-back, beat 0 all 0x80
        run_frame(6, 8, -1, 0, 0, 1, base);
        chk("f1_first_wen", CKW'(lg_wen[base]), CKW'(8'h01));
        chk("f1_last_wen", CKW'(lg_wen[base+7]), CKW'(8'h80));
        chk("f1_last_addr", CKW'(lg_addr[base+7]), CKW'(0));
        chk("f1_span", CKW'(lg_cyc[base+7] - lg_cyc[base]), CKW'(7));
        chk("f1_llr_0x80", CKW'(lg_data[base][9:0]), CKW'(10'h380));
        chk("f1_done_cycle", CKW'(done_cyc), CKW'(lg_cyc[base+7] + 1));

        // Partial frame with zero fill
        run_frame(7, 5, -1, 0, 0, 0, base);
        chk("f2_fill_first_wen", CKW'(lg_wen[base+5]), CKW'(8'h20));
        chk("f2_fill_first_addr", CKW'(lg_addr[base+5][WA-1:0]), CKW'(0));
        chk("f2_bank0_addr1_wen", CKW'(lg_wen[base+8]), CKW'(8'h01));
        chk("f2_bank0_addr1_addr", CKW'(lg_addr[base+8][WA-1:0]), CKW'(1));
        chk("f2_last_fill_data", CKW'(lg_data[base+15]), CKW'(0));

        // No received beats; oversize received length
        run_frame(6, 0, -1, 0, 0, 0, base);
        run_frame(6, 20, -1, 0, 0, 0, base);

        // Early in_last with valid gaps, then a frame that must clear err_len
        run_frame(6, 8, 3, 1, 0, 0, base);
        chk("err_sticky_after_frame", CKW'(err_len), CKW'(1));
        run_frame(6, 8, -1, 1, 0, 0, base);

        // n_log clamping at both ends
        run_frame(3, 3, -1, 0, 0, 0, base);
        run_frame(15, 3, -1, 0, 0, 0, base);

        // cfg_start during LOAD is ignored
        run_frame(7, 10, -1, 0, 1, 0, base);

        for (int r = 0; r < 6; r++) begin
            int nl, eb;
            nl = int'($urandom_range(6, 9));
            eb = int'($urandom_range(0, (1 << (nl - 3)) + 4));
            run_frame(nl, eb, -1, 1'($urandom_range(0, 1)), 0, 0, base);
        end

        // Reset in the middle of LOAD
        beat_q.delete();
        for (int i = 0; i < 16; i++)
            beat_q.push_back({$urandom, $urandom});
        push_frame(16, 16);
        @(negedge clk);
        cfg_start = 1'b1; cfg_n_log = 4'd7; cfg_e_beats = 10'd16;
        @(negedge clk);
        cfg_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_llr   = beat_q[i];
            bus.in_last  = 1'b0;
            @(negedge clk);
        end
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        expq.delete();
        #1;
        chk("mid_rst_wen", CKW'(bus.ulr2sram_llr_wen), CKW'(0));
        chk("mid_rst_wbyte", CKW'(bus.ulr2sram_llr_wbyte), CKW'(0));
        chk("mid_rst_waddr", CKW'(bus.ulr2sram_llr_waddr), CKW'(0));
        chk("mid_rst_wdata", CKW'(bus.ulr2sram_llr_wdata), CKW'(0));
        chk("mid_rst_ready", CKW'(bus.in_ready), CKW'(0));
        chk("mid_rst_busy", CKW'(load_busy), CKW'(0));
        chk("mid_rst_done", CKW'(load_done), CKW'(0));
        chk("mid_rst_err", CKW'(err_len), CKW'(0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("post_rst_busy", CKW'(load_busy), CKW'(0));
        chk("post_rst_ready", CKW'(bus.in_ready), CKW'(0));
        run_frame(6, 8, -1, 1, 0, 0, base);

        // 12-bit input instance: saturating conversion
        @(negedge clk);
        cfg_start12 = 1'b1; cfg_n_log12 = 4'd6; cfg_e_beats12 = 10'd1;
        @(negedge clk);
        cfg_start12 = 1'b0;
        bus12.in_valid = 1'b1;
        bus12.in_last  = 1'b1;
        bus12.in_llr   = {12'h200, 12'hFFF, 12'h001, 12'h000, 12'hF00, 12'h0FF, 12'h800, 12'h7FF};
        chk("w12_ready", CKW'(bus12.in_ready), CKW'(1));
        @(negedge clk);
        bus12.in_valid = 1'b0;
        bus12.in_last  = 1'b0;
        chk("w12_wen", CKW'(bus12.ulr2sram_llr_wen), CKW'(8'h01));
        chk("w12_sat", CKW'(bus12.ulr2sram_llr_wdata[79:0]),
            CKW'({10'h1FF, 10'h3FF, 10'h001, 10'h000, 10'h300, 10'h0FF, 10'h201, 10'h1FF}));
        cnt12 = 1;
        k = 0;
        while (!done12 && k < 30) begin
            @(negedge clk);
            if (bus12.ulr2sram_llr_wen != 8'h00) cnt12++;
            k++;
        end
        chk("w12_done", CKW'(done12), CKW'(1));
        chk("w12_writes", CKW'(cnt12), CKW'(8));
        chk("w12_err", CKW'(err12), CKW'(0));

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pdec_llr_loader.md
Name: pdec_llr_loader

Overview:
Upstream stage of the polar-decoder LLR SRAM bank. It accepts a stream of channel LLRs, 8 per beat, and converts each one from WID_IN to WID_INN bits. It writes one 8-LLR word per beat into the 8 interleaved LLR banks through the ulr2sram_llr_* write port. Beats beyond the received length E are zero-filled (punctured/shortened positions) up to code length N, and load_done is then pulsed to start decoding.

Parameters:
WID_IN, 8, signed input LLR width
WID_INN, 10, signed stored LLR width (matches LLR SRAM)
WID_LLR_ADDR, 6, per-bank word address width; max beats = 8*2^WID_LLR_ADDR

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
cfg_start  in  1  frame start pulse, sampled only in IDLE
cfg_n_log  in  4  log2(N); legal 6..WID_LLR_ADDR+6
cfg_e_beats  in  WID_LLR_ADDR+4  received beats (E/8)
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid&in_ready
in_llr  in  WID_IN*8  8 signed LLRs, LLR j at [WID_IN*j +: WID_IN]
in_last  in  1  marks final received beat
ulr2sram_llr_wen  out  8  one-hot bank write enable
ulr2sram_llr_waddr  out  WID_LLR_ADDR*8  per-bank address; all 8 fields carry the same address
ulr2sram_llr_wbyte  out  80  byte enables, 10 per bank
ulr2sram_llr_wdata  out  WID_INN*64  write data, bank b at [WID_INN*8*b +: WID_INN*8]
load_busy  out  1  high from start acceptance until load_done
load_done  out  1  one-cycle pulse, frame fully written
err_len  out  1  sticky in_last mismatch, cleared by next accepted cfg_start

Behaviour:
- Reset: all outputs 0; FSM in IDLE; counters 0. Reset mid-frame aborts the frame. No write is issued after reset until a new cfg_start.
- Derived values:
  - T = 2^(cfg_n_log-3) beats, latched at start.
  - Eeff = min(cfg_e_beats, T), latched at start.
  - cfg_n_log outside the legal range is clamped to the nearest legal value.
- Beat counter cnt (WID_LLR_ADDR+3 bits): bank = cnt[2:0], addr = cnt[WID_LLR_ADDR+2:3]. Beat i is written to bank i%8, address i/8.
- FSM IDLE/LOAD/FILL/DONE:
  - IDLE: in_ready=0. On cfg_start: go to LOAD if Eeff>0, else FILL; cnt=0; load_busy=1; err_len=0.
  - LOAD: in_ready=1.
    - Each accepted beat issues one write and increments cnt.
    - On the accept with cnt==Eeff-1: go to DONE if Eeff==T, else FILL.
    - in_last on that beat must be 1, and must be 0 on earlier beats. Any violation sets err_len; the counter still governs completion.
  - FILL: in_ready=0. One zero-data write per cycle; cnt increments. On cnt==T-1, go to DONE.
  - DONE: one cycle. load_done=1, load_busy=0 next cycle, then IDLE.
- cfg_start outside IDLE is ignored. Input beats outside LOAD are not accepted.
- Write outputs are registered. An accept or fill step at edge k drives the write bus during the cycle after edge k:
  - wen = one-hot(bank).
  - wbyte[10*bank +: 10] = 10'h3FF; all other wbyte bits 0.
  - wdata bank slot = converted LLRs; other slots 0.
  - When no write is issued, wen and wbyte are 0 and wdata/waddr hold their previous values.
- load_done is asserted in the cycle immediately after the final write cycle.
- Throughput: 1 beat/cycle in LOAD with in_valid held high. in_valid gaps only stall; they create no bubble writes.
- Conversion (signed):
  - If WID_IN<=WID_INN: sign-extend.
  - Otherwise: saturate symmetrically to ±(2^(WID_INN-1)-1); the most negative input also maps to -(2^(WID_INN-1)-1).

Test Plan:
1. n_log=6, e_beats=8, 8 back-to-back beats with in_last on beat 7 -> wen 01,02,..,80 on consecutive cycles, waddr 0; load_done 1 cycle after wen=80; err_len=0.
2. n_log=7, e_beats=5 -> 5 data writes, then 11 zero writes (banks 5..7 addr 0, banks 0..7 addr 1), no in_ready during fill; load_done after write 16.
3. e_beats=0 with n_log=6 -> 8 zero writes, in_ready never high; e_beats=20 with n_log=6 -> clamped to 8, load_done after 8 beats.
4. WID_IN=12, WID_INN=10: inputs 0x7FF, 0x800, 0x0FF, 0xF00 -> stored 511, -511, 255, -256. Default WID_IN=8: input 0x80 -> 10'h380.
5. in_last asserted on beat 3 of 8 -> err_len=1 until next start; frame still completes with 8 writes; in_valid toggling 1/0 -> writes only on accepted beats.
6. rst_n low mid-LOAD -> all outputs 0 immediately. cfg_start during LOAD is ignored; the frame completes with the original T.
